mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH 32 (byte address width), DATA_WIDTH 32 (beat width, fixed 32 bits), and BURST_LEN 4 (beats per cache-line transfer, power of 2, at least 2).
REQ-002 The block SHALL use one clock, clk_i; reset_i SHALL be synchronous and active-high.
REQ-003 The block SHALL have these ports:
  clk_i  in  1  clock
  reset_i  in  1  synchronous active-high reset
  ic_req_valid_i  in  1  icache line-refill request
  ic_req_addr_i  in  ADDR_WIDTH  icache miss address
  ic_req_ready_o  out  1  icache request accepted
  ic_rvalid_o  out  1  refill beat valid
  ic_rdata_o  out  DATA_WIDTH  refill beat data
  ic_beat_o  out  log2(BURST_LEN)  refill beat index
  ic_done_o  out  1  icache transfer complete
  dc_req_valid_i  in  1  dcache refill or writeback request
  dc_req_we_i  in  1  1 = writeback, 0 = refill
  dc_req_addr_i  in  ADDR_WIDTH  dcache line address
  dc_req_ready_o  out  1  dcache request accepted
  dc_wdata_i  in  DATA_WIDTH  writeback word for dc_beat_o
  dc_rvalid_o  out  1  refill beat valid
  dc_rdata_o  out  DATA_WIDTH  refill beat data
  dc_beat_o  out  log2(BURST_LEN)  current beat index
  dc_done_o  out  1  dcache transfer complete
  mem_valid_o  out  1  beat request to memory
  mem_we_o  out  1  beat is a write
  mem_addr_o  out  ADDR_WIDTH  beat byte address
  mem_wdata_o  out  DATA_WIDTH  beat write data
  mem_ready_i  in  1  beat completes this cycle
  mem_rdata_i  in  DATA_WIDTH  read data, valid when mem_ready_i is high

Function
REQ-004 The block SHALL have three FSM states: IDLE, BURST and DONE.
REQ-005 In IDLE, when any request is valid, the block SHALL pulse the winner's req_ready_o combinationally, latch the owner, we and base address (requester address with its low log2(BURST_LEN*4) bits cleared), clear the beat counter, and go to BURST.
REQ-006 Fixed priority SHALL grant dcache over icache when both are valid.
REQ-007 In BURST, the outputs SHALL be: mem_valid_o = 1; mem_addr_o = base + 4*beat; mem_we_o = latched we; mem_wdata_o = dc_wdata_i.
REQ-008 A beat SHALL complete on mem_valid_o && mem_ready_i; the beat counter SHALL then increment; mem_ready_i low SHALL hold all mem outputs stable.
REQ-009 On a completed read beat, the owner's rvalid_o SHALL be 1 in the same cycle, with rdata_o = mem_rdata_i and beat_o = the current beat; the non-owner's rvalid_o SHALL be 0.
REQ-010 Completion of beat BURST_LEN-1 SHALL move the FSM to DONE; the counter SHALL wrap to 0.
REQ-011 DONE SHALL last exactly one cycle: the owner's done_o is 1, mem_valid_o is 0, and no request is accepted; the FSM then returns to IDLE.
REQ-012 Minimum latency from acceptance to done_o SHALL be BURST_LEN+1 cycles; back-to-back transfers SHALL be separated by at least one IDLE cycle.
REQ-013 Outside the states defined above, req_ready_o, rvalid_o, done_o and mem_valid_o SHALL be 0; a request arriving while busy SHALL wait and SHALL NOT be dropped.
REQ-014 An icache write request is not possible; the icache path SHALL always be a read.

Reset
REQ-015 When reset_i is high at a clock edge, the FSM SHALL go to IDLE, with beat counter 0, owner icache and we 0.
REQ-016 All handshake outputs SHALL be 0 while reset_i is high and in the first cycle after reset.
REQ-017 Reset during BURST SHALL abandon the transfer, with no done_o pulse.

Configuration
REQ-018 With MEM_ARBITER_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins, and the last-grant flag resets to icache so that dcache wins first. Without the macro, REQ-006 fixed priority SHALL apply.

Verification
REQ-019 Icache read at 0x104, memory always ready -> beats at 0x100, 0x104, 0x108, 0x10C, ic_beat_o 0..3, ic_done_o at cycle 5 after acceptance.
REQ-020 Dcache writeback at 0x2000 with dc_wdata_i = 0xA0+beat and mem_ready_i low every other cycle -> 4 writes 0xA0..0xA3 at 0x2000..0x200C, outputs held while stalled.
REQ-021 Both request in the same cycle, three times in a row -> order D, I, D with MEM_ARBITER_RR_EN; D, D, D without it.
REQ-022 Dcache request raised during an icache burst -> dc_req_ready_o stays 0 until the cycle after ic_done_o, then the dcache transfer is served.
REQ-023 reset_i asserted after beat 1 of a dcache refill -> next cycle IDLE, no dc_done_o, and a fresh icache request is accepted normally.
REQ-024 Owner isolation -> the non-owner's rvalid_o and done_o stay 0 throughout every transfer.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one beat-wide memory port between an icache and a
// dcache. Each accepted request becomes a BURST_LEN-beat line transfer
// followed by a one-cycle DONE state.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration
// of simultaneous requests; otherwise the dcache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         ic_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]        ic_req_addr_i,
    output logic                         ic_req_ready_o,
    output logic                         ic_rvalid_o,
    output logic [DATA_WIDTH-1:0]        ic_rdata_o,
    output logic [$clog2(BURST_LEN)-1:0] ic_beat_o,
    output logic                         ic_done_o,
    input  logic                         dc_req_valid_i,
    input  logic                         dc_req_we_i,
    input  logic [ADDR_WIDTH-1:0]        dc_req_addr_i,
    output logic                         dc_req_ready_o,
    input  logic [DATA_WIDTH-1:0]        dc_wdata_i,
    output logic                         dc_rvalid_o,
    output logic [DATA_WIDTH-1:0]        dc_rdata_o,
    output logic [$clog2(BURST_LEN)-1:0] dc_beat_o,
    output logic                         dc_done_o,
    output logic                         mem_valid_o,
    output logic                         mem_we_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic                         mem_ready_i,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((BURST_LEN * 4) - 1);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    owner_q, owner_d;   // 1 = dcache owns the transfer
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    rst_dly_q;          // blocks acceptance in the first cycle after reset
    logic                    grant_dc;
    logic                    accept;

`ifdef MEM_ARBITER_RR_EN
    logic                    last_dc_q;          // 1 = dcache was granted last

    // Arbitration: on a tie the requester not granted last wins.
    always_comb begin
        grant_dc = dc_req_valid_i && (!ic_req_valid_i || !last_dc_q);
    end

    // Last-grant flag, reset to icache so the dcache wins the first tie.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_dc_q <= 1'b0;
        end else if (accept) begin
            last_dc_q <= grant_dc;
        end
    end
`else
    // Arbitration: dcache has fixed priority over icache.
    always_comb begin
        grant_dc = dc_req_valid_i;
    end
`endif

    // State register and latched transfer context.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            rst_dly_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            base_q    <= base_d;
            rst_dly_q <= 1'b0;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        owner_d        = owner_q;
        we_d           = we_q;
        base_d         = base_q;
        accept         = 1'b0;
        ic_req_ready_o = 1'b0;
        dc_req_ready_o = 1'b0;
        ic_rvalid_o    = 1'b0;
        dc_rvalid_o    = 1'b0;
        ic_done_o      = 1'b0;
        dc_done_o      = 1'b0;
        mem_valid_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst_dly_q && (ic_req_valid_i || dc_req_valid_i)) begin
                    accept         = 1'b1;
                    ic_req_ready_o = !grant_dc;
                    dc_req_ready_o = grant_dc;
                    owner_d        = grant_dc;
                    we_d           = grant_dc && dc_req_we_i;
                    base_d         = (grant_dc ? dc_req_addr_i : ic_req_addr_i) & ~OFF_MASK;
                    beat_d         = '0;
                    state_d        = BURST;
                end
            end
            BURST: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i) begin
                    ic_rvalid_o = !we_q && !owner_q;
                    dc_rvalid_o = !we_q && owner_q;
                    beat_d      = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ic_done_o = !owner_q;
                dc_done_o = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so the state may still read BURST during the
        // reset cycle; force every handshake quiet regardless.
        if (reset_i) begin
            accept         = 1'b0;
            ic_req_ready_o = 1'b0;
            dc_req_ready_o = 1'b0;
            ic_rvalid_o    = 1'b0;
            dc_rvalid_o    = 1'b0;
            ic_done_o      = 1'b0;
            dc_done_o      = 1'b0;
            mem_valid_o    = 1'b0;
        end
    end

    assign mem_addr_o  = base_q + (ADDR_WIDTH'(beat_q) << 2);
    assign mem_we_o    = we_q;
    assign mem_wdata_o = dc_wdata_i;
    assign ic_rdata_o  = mem_rdata_i;
    assign dc_rdata_o  = mem_rdata_i;
    assign ic_beat_o   = beat_q;
    assign dc_beat_o   = beat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized concurrent traffic,
// checked every cycle against a transaction-level model of the arbiter.
// Honours MEM_ARBITER_RR_EN in its expectations.
module tb_mem_arbiter;

    localparam int BL  = 4;
    localparam int BW  = 2;
    localparam int TMO = 1000;
    localparam logic [31:0] SALT = 32'h5A5A_3C3C;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_v, ic_ready, ic_rvalid, ic_done;
    logic [31:0]   ic_a, ic_rdata;
    logic [BW-1:0] ic_beat;
    logic          dc_v, dc_we, dc_ready, dc_rvalid, dc_done;
    logic [31:0]   dc_a, dc_wdata, dc_rdata;
    logic [BW-1:0] dc_beat;
    logic          mem_valid, mem_we, mem_ready;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;

    logic [31:0]   wbase;
    int unsigned   rdy_mode;
    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic          grants[$];   // 1 = dcache granted

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL)) dut (
        .clk_i(clk), .reset_i(reset),
        .ic_req_valid_i(ic_v), .ic_req_addr_i(ic_a), .ic_req_ready_o(ic_ready),
        .ic_rvalid_o(ic_rvalid), .ic_rdata_o(ic_rdata), .ic_beat_o(ic_beat), .ic_done_o(ic_done),
        .dc_req_valid_i(dc_v), .dc_req_we_i(dc_we), .dc_req_addr_i(dc_a), .dc_req_ready_o(dc_ready),
        .dc_wdata_i(dc_wdata), .dc_rvalid_o(dc_rvalid), .dc_rdata_o(dc_rdata), .dc_beat_o(dc_beat),
        .dc_done_o(dc_done),
        .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Writeback source supplies wbase + beat; memory returns a pattern of the address.
    assign dc_wdata  = wbase + 32'(dc_beat);
    assign mem_rdata = ~mem_addr ^ SALT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory readiness pattern: 0 always ready, 1 alternating, 2 random.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = !mem_ready;
                default: mem_ready = 1'(($urandom_range(0, 1)));
            endcase
        end
    end

    // Reference model: one transfer at a time, tracked as owner/base/beats done.
    int unsigned   m_phase;     // 0 idle, 1 beats outstanding, 2 done expected
    logic          m_blk, m_owner, m_we, m_last_dc, m_stall;
    logic [31:0]   m_base;
    int unsigned   m_k, m_lat;
    logic [6:0]    hs_obs, hs_exp;
    logic          exp_acc, exp_dc;

    initial begin
        m_phase = 0; m_blk = 1'b1; m_last_dc = 1'b0;
    end

    always @(negedge clk) begin
        hs_obs = {ic_ready, dc_ready, ic_rvalid, dc_rvalid, ic_done, dc_done, mem_valid};
        hs_exp = '0;
        if (reset) begin
            check("reset_quiet", 32'(hs_obs), 32'd0);
            m_phase   = 0;
            m_blk     = 1'b1;
            m_last_dc = 1'b0;
        end else begin
            exp_acc = 1'b0;
            exp_dc  = 1'b0;
            case (m_phase)
                0: begin
                    if (!m_blk && (ic_v || dc_v)) begin
                        exp_acc = 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        exp_dc = dc_v && (!ic_v || !m_last_dc);
`else
                        exp_dc = dc_v;
`endif
                        hs_exp[6] = !exp_dc;
                        hs_exp[5] = exp_dc;
                    end
                end
                1: begin
                    m_lat++;
                    hs_exp[0] = 1'b1;
                    check("mem_addr", mem_addr, m_base + 32'(4 * m_k));
                    check("mem_we", 32'(mem_we), 32'(m_we));
                    if (m_we) check("mem_wdata", mem_wdata, wbase + 32'(m_k));
                    if (mem_ready) begin
                        if (!m_we) begin
                            hs_exp[m_owner ? 3 : 4] = 1'b1;
                            check("rdata", m_owner ? dc_rdata : ic_rdata, ~(m_base + 32'(4 * m_k)) ^ SALT);
                            check("beat", 32'(m_owner ? dc_beat : ic_beat), 32'(m_k));
                        end
                        m_k++;
                        if (m_k == BL) m_phase = 2;
                    end else begin
                        m_stall = 1'b1;
                    end
                end
                default: begin
                    m_lat++;
                    hs_exp[m_owner ? 1 : 2] = 1'b1;
                    if (!m_stall) check("latency", 32'(m_lat), 32'(BL + 1));
                    m_phase = 0;
                end
            endcase
            check("handshake", 32'(hs_obs), 32'(hs_exp));
            if (exp_acc) begin
                grants.push_back(dc_ready);
                m_owner   = exp_dc;
                m_last_dc = exp_dc;
                m_we      = exp_dc && dc_we;
                m_base    = (exp_dc ? dc_a : ic_a) & ~32'(BL * 4 - 1);
                m_k       = 0;
                m_lat     = 0;
                m_stall   = 1'b0;
                m_phase   = 1;
            end
            m_blk = 1'b0;
        end
    end

    // Requester tasks: called #1 after a rising edge, return likewise in the
    // cycle after done. The request is held until accepted.
    task automatic ic_xfer(input logic [31:0] a);
        int unsigned n;
        ic_v = 1'b1; ic_a = a; n = 0;
        @(negedge clk);
        while (!ic_ready && n < TMO) begin @(negedge clk); n++; end
        check("ic_accept_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1 ic_v = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ic_done && n < TMO) begin @(negedge clk); n++; end
        check("ic_done_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic dc_xfer(input logic we, input logic [31:0] a);
        int unsigned n;
        dc_v = 1'b1; dc_we = we; dc_a = a; n = 0;
        @(negedge clk);
        while (!dc_ready && n < TMO) begin @(negedge clk); n++; end
        check("dc_accept_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1 dc_v = 1'b0;
        n = 0;
        @(negedge clk);
        while (!dc_done && n < TMO) begin @(negedge clk); n++; end
        check("dc_done_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, seen;
        reset = 1'b1; ic_v = 1'b0; dc_v = 1'b0; dc_we = 1'b0;
        ic_a = '0; dc_a = '0; wbase = 32'hA0; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // icache read, memory always ready
        ic_xfer(32'h104);

        // dcache writeback with memory stalling every other cycle
        rdy_mode = 1; wbase = 32'hA0;
        dc_xfer(1'b1, 32'h2000);

        // simultaneous requests, dcache re-requesting back to back
        rdy_mode = 0;
        grants.delete();
        fork
            ic_xfer(32'h300);
            begin
                dc_xfer(1'b0, 32'h400);
                dc_xfer(1'b0, 32'h440);
                dc_xfer(1'b0, 32'h480);
            end
        join
        check("grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 3) begin
`ifdef MEM_ARBITER_RR_EN
            check("grant_order", {29'd0, grants[0], grants[1], grants[2]}, 32'b101);
`else
            check("grant_order", {29'd0, grants[0], grants[1], grants[2]}, 32'b111);
`endif
        end

        // dcache request raised during an icache burst
        fork
            ic_xfer(32'h500);
            begin
                repeat (2) begin @(posedge clk); #1; end
                dc_xfer(1'b0, 32'h600);
            end
        join

        // reset after beat 1 of a dcache refill
        dc_we = 1'b0; dc_a = 32'h800; dc_v = 1'b1; n = 0;
        @(negedge clk);
        while (!dc_ready && n < TMO) begin @(negedge clk); n++; end
        check("rst_accept_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1 dc_v = 1'b0;
        n = 0; seen = 0;
        while (seen < 2 && n < TMO) begin
            @(negedge clk);
            if (dc_rvalid) seen++;
            n++;
        end
        check("rst_beats_seen", 32'(seen), 32'd2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abandoned_no_done", 32'(dc_done), 32'd0);
        end
        @(posedge clk); #1;
        ic_xfer(32'h904);

        // randomized concurrent traffic with random memory stalls
        rdy_mode = 2;
        wbase = $urandom;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ic_xfer($urandom);
                end
            end
            begin
                for (int j = 0; j < 15; j++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    dc_xfer(1'(($urandom_range(0, 1))), $urandom);
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
